// File: rtl/rate_sel_ctrl.sv
// Rate-select controller: free-running prescaler with four power-of-two tick rates,
// button-driven rate selection committed only on a tick of the current rate.
module rate_sel_ctrl #(
   parameter int CNT_W = 26,
   parameter int TAP0  = 19,
   parameter int TAP1  = 21,
   parameter int TAP2  = 23,
   parameter int TAP3  = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_up,
   input  logic       btn_dn,
   input  logic       en,
   output logic [1:0] sel,
   output logic       pending,
   output logic       tick_o,
   output logic [3:0] ticks
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] PEND = 1'b1;

   logic [CNT_W-1:0] cnt;
   logic [0:0]       state;
   logic [1:0]       psel;
   logic             btn_up_q;
   logic             btn_dn_q;
   logic             up_e;
   logic             dn_e;
   logic             up_v;
   logic             dn_v;
   logic             edge_v;
   logic [1:0]       step;
   logic             tick_sel;

   assign ticks[0] = &cnt[TAP0:0];
   assign ticks[1] = &cnt[TAP1:0];
   assign ticks[2] = &cnt[TAP2:0];
   assign ticks[3] = &cnt[TAP3:0];

   assign up_e   = btn_up & ~btn_up_q;
   assign dn_e   = btn_dn & ~btn_dn_q;
   // Simultaneous up and down presses cancel each other out.
   assign up_v   = up_e & ~dn_e;
   assign dn_v   = dn_e & ~up_e;
   assign edge_v = up_v | dn_v;
   assign step   = up_v ? 2'd1 : 2'd3;

   assign tick_sel = ticks[sel];
   assign pending  = (state == PEND);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         state    <= IDLE;
         sel      <= 2'd0;
         psel     <= 2'd0;
         tick_o   <= 1'b0;
         // NOTE: button history resets to 1 so a button held through reset is not seen as a press.
         btn_up_q <= 1'b1;
         btn_dn_q <= 1'b1;
      end else begin
         cnt      <= cnt + CNT_W'(1);
         btn_up_q <= btn_up;
         btn_dn_q <= btn_dn;
         // Uses sel before any same-cycle commit, so the committing tick is at the old rate.
         tick_o   <= tick_sel & en;

         case (state)
            IDLE: begin
               if (edge_v) begin
                  psel  <= sel + step;
                  state <= PEND;
               end
            end
            default: begin
               if (edge_v) begin
                  psel <= psel + step;
               end
               if (tick_sel) begin
                  sel <= psel;
                  if (!edge_v) begin
                     state <= IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rate_sel_ctrl.sv
// Directed bench for rate_sel_ctrl with a cycle-level reference model feeding a scoreboard
// of expected outputs, plus directed checks at the interesting cycles.
module tb_rate_sel_ctrl;

   localparam int CNT_W = 5;
   localparam int TAPS[4] = '{1, 2, 3, 4};

   typedef struct packed {
      logic [1:0] sel;
      logic       pend;
      logic       tick;
      logic [3:0] ticks;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_dn = 1'b0;
   logic       en = 1'b1;
   logic [1:0] sel;
   logic       pending;
   logic       tick_o;
   logic [3:0] ticks;

   int total = 0;
   int bad = 0;

   exp_t sb_q[$];

   // reference model state
   int         m_cnt = 0;
   logic [1:0] m_sel = 2'd0;
   logic [1:0] m_psel = 2'd0;
   logic       m_pend = 1'b0;
   logic       m_tick = 1'b0;
   logic       m_upq = 1'b1;
   logic       m_dnq = 1'b1;

   rate_sel_ctrl #(
      .CNT_W(CNT_W), .TAP0(1), .TAP1(2), .TAP2(3), .TAP3(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn), .en(en),
      .sel(sel), .pending(pending), .tick_o(tick_o), .ticks(ticks)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] ref_ticks(input int c);
      logic [3:0] t;
      for (int k = 0; k < 4; k++) begin
         int period;
         period = 1 << (TAPS[k] + 1);
         t[k] = ((c % period) == (period - 1));
      end
      return t;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model across one rising edge using the inputs the DUT sampled.
   task automatic model_step();
      logic [3:0] tk;
      logic       up_e, dn_e, has;
      logic [1:0] d;
      if (!rst_n) begin
         m_cnt = 0; m_sel = 2'd0; m_psel = 2'd0; m_pend = 1'b0;
         m_tick = 1'b0; m_upq = 1'b1; m_dnq = 1'b1;
      end else begin
         tk   = ref_ticks(m_cnt);
         up_e = btn_up & ~m_upq;
         dn_e = btn_dn & ~m_dnq;
         has  = up_e ^ dn_e;
         d    = up_e ? 2'd1 : 2'd3;
         m_tick = tk[m_sel] & en;
         if (m_pend && tk[m_sel]) begin
            m_sel = m_psel;
            if (has) m_psel = m_psel + d;
            else     m_pend = 1'b0;
         end else if (m_pend && has) begin
            m_psel = m_psel + d;
         end else if (!m_pend && has) begin
            m_psel = m_sel + d;
            m_pend = 1'b1;
         end
         m_cnt = (m_cnt + 1) % (1 << CNT_W);
         m_upq = btn_up;
         m_dnq = btn_dn;
      end
   endtask

   task automatic cyc();
      exp_t e;
      exp_t got;
      @(posedge clk);
      model_step();
      sb_q.push_back('{sel: m_sel, pend: m_pend, tick: m_tick, ticks: ref_ticks(m_cnt)});
      #1;
      e = sb_q.pop_front();
      got = '{sel: sel, pend: pending, tick: tick_o, ticks: ticks};
      check("sb_sel", 8'(got.sel), 8'(e.sel));
      check("sb_pending", 8'(got.pend), 8'(e.pend));
      check("sb_tick_o", 8'(got.tick), 8'(e.tick));
      check("sb_ticks", 8'(got.ticks), 8'(e.ticks));
   endtask

   task automatic wait_cnt(input int target);
      int n;
      n = 0;
      while (m_cnt != target && n < 64) begin
         cyc();
         n++;
      end
      check("wait_cnt_bound", 8'(m_cnt == target), 8'd1);
   endtask

   initial begin
      // 1. reset with btn_up held
      btn_up = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("rst_sel", 8'(sel), 8'd0);
         check("rst_pending", 8'(pending), 8'd0);
         check("rst_tick_o", 8'(tick_o), 8'd0);
         check("rst_ticks", 8'(ticks), 8'd0);
      end
      rst_n = 1'b1;
      cyc();
      cyc();
      check("held_btn_no_edge", 8'(pending), 8'd0);
      btn_up = 1'b0;
      wait_cnt(4);
      check("rate0_tick_at4", 8'(tick_o), 8'd1);
      wait_cnt(5);
      check("rate0_idle_at5", 8'(tick_o), 8'd0);

      // 2. deferred switch, button pressed during cnt=5
      btn_up = 1'b1;
      cyc();
      check("pend_latency", 8'(pending), 8'd1);
      btn_up = 1'b0;
      cyc();
      check("sel_before_commit", 8'(sel), 8'd0);
      cyc();
      check("commit_sel1", 8'(sel), 8'd1);
      check("commit_tick_old_rate", 8'(tick_o), 8'd1);
      check("commit_pending_clr", 8'(pending), 8'd0);
      wait_cnt(12);
      check("rate1_no_tick_at12", 8'(tick_o), 8'd0);
      wait_cnt(16);
      check("rate1_tick_at16", 8'(tick_o), 8'd1);

      // 3. three accumulated up edges: 1->2->3->0
      wait_cnt(17);
      for (int i = 0; i < 3; i++) begin
         btn_up = 1'b1;
         cyc();
         btn_up = 1'b0;
         cyc();
      end
      check("accum_wait_sel", 8'(sel), 8'd1);
      check("accum_wait_pend", 8'(pending), 8'd1);
      cyc();
      check("accum_commit_sel0", 8'(sel), 8'd0);
      check("accum_commit_pend", 8'(pending), 8'd0);

      // 4. down wrap to rate 3, then cancelled simultaneous press
      btn_dn = 1'b1;
      cyc();
      btn_dn = 1'b0;
      wait_cnt(28);
      check("dn_wrap_sel3", 8'(sel), 8'd3);
      wait_cnt(0);
      check("rate3_tick_at0", 8'(tick_o), 8'd1);
      wait_cnt(4);
      check("rate3_no_tick_at4", 8'(tick_o), 8'd0);
      btn_up = 1'b1;
      btn_dn = 1'b1;
      cyc();
      check("cancel_pending", 8'(pending), 8'd0);
      check("cancel_sel", 8'(sel), 8'd3);
      btn_up = 1'b0;
      btn_dn = 1'b0;
      cyc();
      check("cancel_release_pending", 8'(pending), 8'd0);

      // 5. psel=2 pending, up edge lands on the commit cycle
      btn_dn = 1'b1;
      cyc();
      btn_dn = 1'b0;
      wait_cnt(31);
      btn_up = 1'b1;
      cyc();
      check("edge_on_commit_sel2", 8'(sel), 8'd2);
      check("edge_on_commit_pend", 8'(pending), 8'd1);
      btn_up = 1'b0;
      wait_cnt(16);
      check("psel3_commit_sel", 8'(sel), 8'd3);
      check("psel3_commit_pend", 8'(pending), 8'd0);

      // 6. enable gating while a change commits, then reset mid-PEND
      en = 1'b0;
      btn_dn = 1'b1;
      cyc();
      btn_dn = 1'b0;
      for (int i = 0; i < 39; i++) begin
         cyc();
         check("gated_tick_o", 8'(tick_o), 8'd0);
      end
      check("gated_commit_sel2", 8'(sel), 8'd2);
      check("gated_commit_pend", 8'(pending), 8'd0);
      en = 1'b1;
      btn_up = 1'b1;
      cyc();
      check("pre_rst_pend", 8'(pending), 8'd1);
      btn_up = 1'b0;
      rst_n = 1'b0;
      cyc();
      check("midpend_rst_pend", 8'(pending), 8'd0);
      check("midpend_rst_sel", 8'(sel), 8'd0);
      check("midpend_rst_ticks", 8'(ticks), 8'd0);
      rst_n = 1'b1;
      wait_cnt(4);
      check("post_rst_rate0_tick", 8'(tick_o), 8'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
